// File: rtl/ls_quad_access.sv
// Quadword Local Storage access unit: turns one 128-bit load/store request
// into 16 sequential byte beats on the registered exmemory port.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE (and never while reset is low). A request
// presented while busy is ignored, so the requester keeps req_valid high.
// resp_valid is a one-cycle pulse with no back-pressure.
module ls_quad_access #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_adr,
    input  logic [127:0]     req_wdata,
    output logic             resp_valid,
    output logic [127:0]     resp_rdata,
    input  logic [WIDTH-1:0] memdata,
    output logic             memread,
    output logic             memwrite,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata,
    output logic [1:0]       dbg_state
);

    localparam int         QBYTES = 16;
    localparam logic [3:0] LAST   = 4'(QBYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-5:0]   base_q, base_d;
    logic [119:0]       wbuf_q, wbuf_d;
    logic [119:0]       rbuf_q, rbuf_d;
    logic               memread_d, memwrite_d, resp_valid_d;
    logic [WIDTH-1:0]   adr_d, writedata_d;
    logic [127:0]       rdata_d;

    logic unused_bits;
    assign unused_bits = ^{memdata[WIDTH-1:8], req_adr[3:0]};

    assign req_ready = (state_q == IDLE) && reset;
    assign dbg_state = state_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        wbuf_d       = wbuf_q;
        rbuf_d       = rbuf_q;
        memread_d    = 1'b0;
        memwrite_d   = 1'b0;
        resp_valid_d = 1'b0;
        adr_d        = adr;
        writedata_d  = writedata;
        rdata_d      = resp_rdata;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    base_d = req_adr[WIDTH-1:4];
                    cnt_d  = 4'd0;
                    adr_d  = {req_adr[WIDTH-1:4], 4'h0};
                    if (req_write) begin
                        state_d     = WRITE;
                        memwrite_d  = 1'b1;
                        wbuf_d      = req_wdata[119:0];
                        writedata_d = {{(WIDTH-8){1'b0}}, req_wdata[127:120]};
                    end else begin
                        state_d   = READ;
                        memread_d = 1'b1;
                    end
                end
            end
            READ: begin
                // Shift in MSB-first so byte 0 ends up in [127:120].
                rbuf_d = {rbuf_q[111:0], memdata[7:0]};
                if (cnt_q == LAST) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    rdata_d      = {rbuf_q, memdata[7:0]};
                end else begin
                    cnt_d     = cnt_q + 4'd1;
                    memread_d = 1'b1;
                    adr_d     = {base_q, cnt_d};
                end
            end
            WRITE: begin
                if (cnt_q == LAST) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d       = cnt_q + 4'd1;
                    memwrite_d  = 1'b1;
                    adr_d       = {base_q, cnt_d};
                    writedata_d = {{(WIDTH-8){1'b0}}, wbuf_q[119:112]};
                    wbuf_d      = {wbuf_q[111:0], 8'h00};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            base_q     <= '0;
            wbuf_q     <= '0;
            rbuf_q     <= '0;
            memread    <= 1'b0;
            memwrite   <= 1'b0;
            resp_valid <= 1'b0;
            adr        <= '0;
            writedata  <= '0;
            resp_rdata <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            wbuf_q     <= wbuf_d;
            rbuf_q     <= rbuf_d;
            memread    <= memread_d;
            memwrite   <= memwrite_d;
            resp_valid <= resp_valid_d;
            adr        <= adr_d;
            writedata  <= writedata_d;
            resp_rdata <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ls_quad_access.sv
// Bench for ls_quad_access: directed vector table, hand-written reset-abort
// sequence, and randomized traffic against a byte-array memory model.
module tb_ls_quad_access;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid, req_ready, req_write;
    logic [W-1:0]   req_adr;
    logic [127:0]   req_wdata;
    logic           resp_valid;
    logic [127:0]   resp_rdata;
    logic [W-1:0]   memdata;
    logic           memread, memwrite;
    logic [W-1:0]   adr, writedata;
    logic [1:0]     dbg_state;

    ls_quad_access #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_adr(req_adr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .memdata(memdata), .memread(memread), .memwrite(memwrite),
        .adr(adr), .writedata(writedata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Local Storage model: 256 bytes selected by adr[7:0]; full adr is checked separately.
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    assign memdata = {24'h0, mem[adr[7:0]]};
    always @(posedge clk) if (memwrite) mem[adr[7:0]] <= writedata[7:0];

    function automatic logic [7:0] fill_byte(input int i);
        logic [7:0] b;
        b = i[7:0];
        if (i < 128) return {b[3:0], b[3:0]};
        return ~b;
    endfunction

    initial for (int i = 0; i < 256; i++) mem[i] = fill_byte(i);

    int checks = 0;
    int errors = 0;
    logic [127:0] last_rdata;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checks++;
        if (memread && memwrite) begin
            errors++;
            $display("FAIL rd_wr_exclusive actual=11 required=not both");
        end
    end

    function automatic logic [127:0] model_load(input logic [31:0] a);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = ref_mem[{a[7:4], 4'(k)}];
        return r;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [127:0] wd);
        for (int k = 0; k < 16; k++) ref_mem[{a[7:4], 4'(k)}] = wd[127-8*k -: 8];
    endtask

    // Called at a negedge; returns at the negedge of cycle E+18.
    task automatic run_txn(input logic wr, input logic [31:0] a, input logic [127:0] wd,
                           input logic [127:0] exp_rd, input bit hold, output int wc);
        req_valid = 1'b1; req_write = wr; req_adr = a; req_wdata = wd;
        wc = 0;
        while (!req_ready && wc < 40) begin @(negedge clk); wc++; end
        chk("accept_ready", {127'b0, req_ready}, 128'd1);
        if (!req_ready) begin req_valid = 1'b0; return; end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("beat%0d_adr", k), adr, {a[31:4], 4'(k)});
            chk($sformatf("beat%0d_memread", k), memread, !wr);
            chk($sformatf("beat%0d_memwrite", k), memwrite, wr);
            if (wr) chk($sformatf("beat%0d_wdata", k), writedata, {24'h0, wd[127-8*k -: 8]});
            chk($sformatf("beat%0d_resp_valid", k), resp_valid, 1'b0);
            chk($sformatf("beat%0d_req_ready", k), req_ready, 1'b0);
            chk($sformatf("beat%0d_rdata_hold", k), resp_rdata, last_rdata);
            @(negedge clk);
        end
        chk("done_resp_valid", resp_valid, 1'b1);
        chk("done_strobes", {memread, memwrite}, 2'b00);
        chk("done_rdata", resp_rdata, exp_rd);
        if (!wr) last_rdata = exp_rd;
        else model_store(a, wd);
        @(negedge clk);
        chk("after_req_ready", req_ready, 1'b1);
        chk("after_resp_valid", resp_valid, 1'b0);
        chk("after_rdata", resp_rdata, last_rdata);
    endtask

    typedef struct {
        logic         wr;
        logic [31:0]  a;
        logic [127:0] wd;
        logic [127:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int wc;
        logic [127:0] wd;
        logic [31:0]  a;
        logic         wr;
        bit           hold;

        vecs[0] = '{1'b0, 32'h0000_0020, 128'h0, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF};
        vecs[1] = '{1'b1, 32'h0000_0045, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,
                    128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF};
        vecs[2] = '{1'b0, 32'h0000_0040, 128'h0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D};
        vecs[3] = '{1'b0, 32'hFFFF_FFF0, 128'h0, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100};
        vecs[4] = '{1'b1, 32'hFFFF_FFF7, 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00,
                    128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 128'h0, 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00};

        for (int i = 0; i < 256; i++) ref_mem[i] = fill_byte(i);
        last_rdata = '0;
        req_valid = 1'b0; req_write = 1'b0; req_adr = '0; req_wdata = '0;

        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_strobes", {memread, memwrite, resp_valid}, 3'b000);
        chk("rst_adr", adr, 32'h0);
        chk("rst_writedata", writedata, 32'h0);
        chk("rst_rdata", resp_rdata, 128'h0);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_state", dbg_state, 2'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rel_req_ready", req_ready, 1'b1);
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_txn(vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].exp_rd, 1'b0, wc);
        chk("mem_40", mem[8'h40], 8'hDE);
        chk("mem_4f", mem[8'h4F], 8'h0D);

        // Back-to-back with req_valid held high throughout.
        run_txn(1'b0, 32'h0000_0020, 128'h0, model_load(32'h20), 1'b1, wc);
        run_txn(1'b1, 32'h0000_0030, 128'hA5A5_0101_F0F0_1234_5678_9ABC_DEF0_0F0F,
                last_rdata, 1'b1, wc);
        chk("b2b_accept_e18", wc, 0);
        req_valid = 1'b0;
        run_txn(1'b0, 32'h0000_0030, 128'h0, model_load(32'h30), 1'b0, wc);

        // Reset in the middle of a store, after beat 5 has been written.
        wd = 128'h8899_AABB_CCDD_EEFF_0011_2233_4455_6677;
        req_valid = 1'b1; req_write = 1'b1; req_adr = 32'h0000_0083; req_wdata = wd;
        wc = 0;
        while (!req_ready && wc < 40) begin @(negedge clk); wc++; end
        chk("abort_accept", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 6; k++) @(negedge clk);
        chk("abort_beat6_live", memwrite, 1'b1);
        reset = 1'b0;
        #1;
        chk("abort_memwrite", memwrite, 1'b0);
        chk("abort_adr", adr, 32'h0);
        chk("abort_req_ready", req_ready, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("abort_rel_ready", req_ready, 1'b1);
        for (int k = 0; k < 16; k++) begin
            if (k <= 5) ref_mem[8'h80 + k] = wd[127-8*k -: 8];
            chk($sformatf("abort_mem%0d", k), mem[8'h80 + k], ref_mem[8'h80 + k]);
        end
        last_rdata = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("abort_no_resp", resp_valid, 1'b0);
        end
        chk("abort_rdata_cleared", resp_rdata, 128'h0);
        run_txn(1'b0, 32'h0000_0080, 128'h0, model_load(32'h80), 1'b0, wc);

        // Randomized traffic against the memory model.
        for (int n = 0; n < 30; n++) begin
            wr = 1'($urandom_range(0, 1));
            a = $urandom;
            wd = {$urandom, $urandom, $urandom, $urandom};
            hold = 1'($urandom_range(0, 1));
            run_txn(wr, a, wd, wr ? last_rdata : model_load(a), hold, wc);
            if (!hold) begin
                for (int g = $urandom_range(0, 3); g > 0; g--) begin
                    @(negedge clk);
                    chk("idle_ready", req_ready, 1'b1);
                end
            end
        end
        req_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
